// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave backed by a word-addressed register file with byte strobes,
// read-only registers and SLVERR decode. Independent write and read FSMs.
//   state   | meaning
//   WR_IDLE | collecting AW and W into one-deep holders
//   WR_RESP | write committed, presenting B until accepted
//   RD_IDLE | ready for a read address
//   RD_DATA | presenting R until accepted
module axi_lite_regfile_slave #(
  parameter int                  ADDR_W    = 32,
  parameter int                  DATA_W    = 32,
  parameter int                  NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = 'h1000,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              aw_hs, w_hs, ar_hs, b_hs, wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_err, rd_err;

  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] word;
    word = (a - BASE_ADDR) >> OFF_W;
    return (a < BASE_ADDR) || (word >= ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] word;
    word = (a - BASE_ADDR) >> OFF_W;
    return word[IDX_W-1:0];
  endfunction

  // Holder contents win over the live bus once a channel has handshaked.
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign wr_idx  = addr_idx(wr_addr);
  assign wr_err  = addr_err(wr_addr) || RO_MASK[wr_idx];
  assign rd_idx  = addr_idx(araddr);
  assign rd_err  = addr_err(araddr);

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign bvalid = (wr_state == WR_RESP);
  assign rvalid = (rd_state == RD_DATA);
  assign b_hs   = bvalid && bready;

  always_comb begin
    wr_state_nxt = wr_state;
    awready      = 1'b0;
    wready       = 1'b0;
    wr_commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        awready = !areset && !aw_held;
        wready  = !areset && !w_held;
        if ((aw_held || (awvalid && awready)) && (w_held || (wvalid && wready))) begin
          wr_commit    = 1'b1;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: if (bready) wr_state_nxt = WR_IDLE;
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    arready      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready = !areset;
        if (arvalid && arready) rd_state_nxt = RD_DATA;
      end
      RD_DATA: if (rready) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (wr_commit) bresp <= wr_err ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && !wr_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Sampled before any same-edge commit lands, so a colliding read returns the old value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_hs) begin
      rdata <= rd_err ? '0 : regs[rd_idx];
      rresp <= rd_err ? 2'b10 : 2'b00;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave: scoreboard queues hold expected
// B/R responses and register images, popped when the DUT presents them.
module tb_axi_lite_regfile_slave;

  localparam logic [15:0] RO_MASK_TB = 16'h0001;

  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  awaddr, wdata, araddr;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [511:0] reg_q;

  int checks = 0;
  int errors = 0;

  logic [31:0]  model [16];
  logic [1:0]   exp_b[$];
  logic [511:0] exp_img[$];
  logic [31:0]  exp_rd[$];
  logic [1:0]   exp_rr[$];

  axi_lite_regfile_slave #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .BASE_ADDR(32'h1000), .RO_MASK(RO_MASK_TB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input bit wr);
    logic [31:0] w;
    if (a < 32'h1000) return 2'b10;
    w = (a - 32'h1000) >> 2;
    if (w >= 32'd16) return 2'b10;
    if (wr && RO_MASK_TB[w[3:0]]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit           aw_done, w_done, hs_aw, hs_w;
    int           cyc;
    logic [1:0]   r, br;
    logic [511:0] img_before;
    logic [31:0]  w;
    img_before = flat();
    r = exp_resp(a, 1'b1);
    exp_b.push_back(r);
    if (r == 2'b00) begin
      w = (a - 32'h1000) >> 2;
      for (int b = 0; b < 4; b++) if (s[b]) model[w[3:0]][8*b +: 8] = d[8*b +: 8];
    end
    exp_img.push_back(flat());
    aw_done = 0; w_done = 0; cyc = 0;
    @(negedge aclk);
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && (cyc >= aw_dly); awaddr = a;
      wvalid  = !w_done && (cyc >= w_dly);   wdata = d; wstrb = s;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (aw_done != w_done) begin
        check("hold_awready", awready, !aw_done);
        check("hold_wready", wready, !w_done);
        check("hold_reg_q", reg_q, img_before);
      end
      @(posedge aclk);
      @(negedge aclk);
      if (hs_aw) aw_done = 1;
      if (hs_w) w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake_timeout", aw_done && w_done, 1'b1);
    check("b_latency", bvalid, 1'b1);
    br = exp_b.pop_front();
    check("bresp", bresp, br);
    check("wr_reg_q", reg_q, exp_img.pop_front());
    check("resp_awready", awready, 1'b0);
    check("resp_wready", wready, 1'b0);
    repeat (b_dly) begin
      @(posedge aclk);
      @(negedge aclk);
      check("b_stall_bvalid", bvalid, 1'b1);
      check("b_stall_bresp", bresp, br);
      check("b_stall_awready", awready, 1'b0);
      check("b_stall_wready", wready, 1'b0);
    end
    bready = 1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 0;
    check("b_done_bvalid", bvalid, 1'b0);
    check("b_done_awready", awready, 1'b1);
    check("b_done_wready", wready, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly);
    int          cyc;
    logic [1:0]  rr;
    logic [31:0] rd, w;
    rr = exp_resp(a, 1'b0);
    w = (a - 32'h1000) >> 2;
    exp_rr.push_back(rr);
    exp_rd.push_back((rr == 2'b00) ? model[w[3:0]] : 32'h0);
    @(negedge aclk);
    arvalid = 1; araddr = a; cyc = 0;
    while (!arready && cyc < 20) begin
      @(posedge aclk);
      @(negedge aclk);
      cyc++;
    end
    check("ar_timeout", arready, 1'b1);
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0;
    rd = exp_rd.pop_front();
    rr = exp_rr.pop_front();
    check("r_latency", rvalid, 1'b1);
    check("rdata", rdata, rd);
    check("rresp", rresp, rr);
    check("rd_arready", arready, 1'b0);
    repeat (r_dly) begin
      @(posedge aclk);
      @(negedge aclk);
      check("r_stall_rvalid", rvalid, 1'b1);
      check("r_stall_rdata", rdata, rd);
    end
    rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 0;
    check("r_done_rvalid", rvalid, 1'b0);
    check("r_done_arready", arready, 1'b1);
  endtask

  initial begin
    areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;

    @(negedge aclk);
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_bvalid", bvalid, 1'b0);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_reg_q", reg_q, 512'h0);
    areset = 0;
    @(posedge aclk);
    @(negedge aclk);
    check("rel_awready", awready, 1'b1);
    check("rel_wready", wready, 1'b1);
    check("rel_arready", arready, 1'b1);

    // 1: same-cycle AW/W, then read back
    do_write(32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h1004, 0);
    check("t1_reg1", reg_q[1*32 +: 32], 32'hDEADBEEF);

    // 2: W first, AW three cycles later
    do_write(32'h1004, 32'h12345678, 4'hF, 3, 0, 0);
    do_read(32'h1004, 2);

    // 3: byte-lane merge, zero strobe, misaligned read
    do_write(32'h1008, 32'h11223344, 4'hF, 0, 0, 0);
    do_write(32'h1008, 32'h0000AB00, 4'b0010, 0, 0, 0);
    check("t3_reg2", reg_q[2*32 +: 32], 32'h1122AB44);
    do_write(32'h1008, 32'hFFFFFFFF, 4'b0000, 1, 0, 0);
    do_read(32'h100B, 0);

    // 4: decode errors and read-only register
    do_write(32'h1040, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(32'h0FFC, 0);
    do_read(32'h1040, 0);
    do_write(32'h1000, 32'h87654321, 4'hF, 0, 0, 0);
    check("t4_reg0", reg_q[31:0], 32'h0);

    // 5: B back-pressure while a read completes
    fork
      do_write(32'h100C, 32'hCAFEF00D, 4'hF, 0, 0, 5);
      begin
        @(negedge aclk);
        do_read(32'h1004, 0);
      end
    join
    do_read(32'h100C, 1);

    // 6: reset with rvalid high and a W held
    @(negedge aclk);
    arvalid = 1; araddr = 32'h1004;
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 0;
    wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
    @(posedge aclk);
    @(negedge aclk);
    wvalid = 0;
    check("t6_pre_rvalid", rvalid, 1'b1);
    check("t6_pre_w_held", wready, 1'b0);
    areset = 1;
    @(posedge aclk);
    @(negedge aclk);
    check("t6_rvalid", rvalid, 1'b0);
    check("t6_bvalid", bvalid, 1'b0);
    check("t6_reg_q", reg_q, 512'h0);
    check("t6_rdata", rdata, 32'h0);
    check("t6_rst_awready", awready, 1'b0);
    check("t6_rst_arready", arready, 1'b0);
    areset = 0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    @(posedge aclk);
    @(negedge aclk);
    check("t6_rel_awready", awready, 1'b1);
    check("t6_rel_wready", wready, 1'b1);
    check("t6_rel_arready", arready, 1'b1);
    do_write(32'h1008, 32'h0BADF00D, 4'hF, 0, 3, 0);
    do_read(32'h1008, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
